// File: rtl/pkt_ring_writer_if.sv
// Bundle of the ingress stream, DMA command/data and ring-pointer signals
// of pkt_ring_writer. The master side is the writer itself.
interface pkt_ring_writer_if #(
    parameter int ADDRESS_BITS = 32,
    parameter int LENGTH_BITS  = 32
);
    logic [31:0]             s_tdata;
    logic [3:0]              s_tkeep;
    logic                    s_tlast;
    logic                    s_tvalid;
    logic                    s_tready;
    logic [ADDRESS_BITS-1:0] cmd_address;
    logic [LENGTH_BITS-1:0]  cmd_bytes;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [31:0]             dout_tdata;
    logic [3:0]              dout_tkeep;
    logic                    dout_tlast;
    logic                    dout_tvalid;
    logic                    dout_tready;
    logic [LENGTH_BITS-1:0]  rd_ptr;
    logic [LENGTH_BITS-1:0]  wr_ptr;
    logic                    pkt_done;
    logic [15:0]             drop_count;

    modport master (
        input  s_tdata, s_tkeep, s_tlast, s_tvalid, cmd_ready, dout_tready, rd_ptr,
        output s_tready, cmd_address, cmd_bytes, cmd_valid,
               dout_tdata, dout_tkeep, dout_tlast, dout_tvalid, wr_ptr, pkt_done, drop_count
    );
    modport slave (
        output s_tdata, s_tkeep, s_tlast, s_tvalid, cmd_ready, dout_tready, rd_ptr,
        input  s_tready, cmd_address, cmd_bytes, cmd_valid,
               dout_tdata, dout_tkeep, dout_tlast, dout_tvalid, wr_ptr, pkt_done, drop_count
    );
endinterface

// File: rtl/pkt_ring_writer.sv
// Store-and-forward packet scheduler: buffers a whole stream packet, allocates
// ring space for it, issues one DMA command plus data, then publishes wr_ptr.
module pkt_ring_writer #(
    parameter logic [31:0] RING_BASE    = 32'h0000_0000,
    parameter int          RING_BYTES   = 65536,
    parameter int          DATA_DEPTH   = 512,
    parameter int          LEN_DEPTH    = 16,
    parameter int          ADDRESS_BITS = 32,
    parameter int          LENGTH_BITS  = 32
) (
    input  logic              aclk,
    input  logic              areset,
    pkt_ring_writer_if.master bus
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam int RBW = $clog2(RING_BYTES);
    localparam int PBW = DAW + 3;
    localparam int CW  = LENGTH_BITS + 1;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CMD, S_DATA, S_DONE} state_t;

    logic [35:0]    dmem [DATA_DEPTH];
    logic [PBW-1:0] lmem [LEN_DEPTH];

    logic [DAW:0]   dwr, dcommit, drd;
    logic [LAW:0]   lwr, lrd;
    logic [PBW-1:0] pkt_bytes, pop, nb;
    logic           drop_mode;
    logic [15:0]    drops;
    logic data_full, len_full, len_empty, pkt_full;
    logic acc, store, commit, rewind, enter_drop;

    // ---------------- ingress ----------------
    assign data_full = (dwr - drd) == (DAW+1)'(DATA_DEPTH);
    assign pkt_full  = (dwr - dcommit) == (DAW+1)'(DATA_DEPTH);
    assign len_full  = (lwr - lrd) == (LAW+1)'(LEN_DEPTH);
    assign len_empty = (lwr == lrd);

    assign pop = PBW'(bus.s_tkeep[0]) + PBW'(bus.s_tkeep[1])
               + PBW'(bus.s_tkeep[2]) + PBW'(bus.s_tkeep[3]);
    assign nb  = pkt_bytes + pop;

    // An oversize packet keeps draining so it can never wedge the input.
    assign bus.s_tready = !areset && (drop_mode || pkt_full || (!data_full && !len_full));

    assign acc        = bus.s_tvalid && bus.s_tready;
    assign store      = acc && !drop_mode && !pkt_full;
    assign commit     = store && bus.s_tlast && (nb != '0);
    assign rewind     = acc && bus.s_tlast && !commit;
    assign enter_drop = acc && !bus.s_tlast && pkt_full;

    always_ff @(posedge aclk) begin
        if (store)  dmem[dwr[DAW-1:0]] <= {bus.s_tkeep, bus.s_tdata};
        if (commit) lmem[lwr[LAW-1:0]] <= nb;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dwr       <= '0;
            dcommit   <= '0;
            lwr       <= '0;
            pkt_bytes <= '0;
            drop_mode <= 1'b0;
            drops     <= '0;
        end else begin
            if (store) begin
                dwr       <= dwr + 1'b1;
                pkt_bytes <= nb;
            end
            if (commit) begin
                lwr       <= lwr + 1'b1;
                dcommit   <= dwr + 1'b1;
                pkt_bytes <= '0;
            end
            if (rewind) begin
                dwr       <= dcommit;
                pkt_bytes <= '0;
                drop_mode <= 1'b0;
                if (drops != 16'hFFFF) drops <= drops + 16'd1;
            end
            if (enter_drop) drop_mode <= 1'b1;
        end
    end

    // ---------------- egress ----------------
    state_t                  state;
    logic [RBW-1:0]          wr, next_wr_r;
    logic [DAW:0]            words_left;
    logic                    cmd_valid_r, pkt_done_r;
    logic [ADDRESS_BITS-1:0] cmd_addr_r;
    logic [LENGTH_BITS-1:0]  cmd_bytes_r;
    logic [PBW-1:0]          bytes_h;
    logic [CW-1:0]           alen, need, free;
    logic [RBW-1:0]          start_c;
    logic                    no_wrap, space_ok;
    logic [35:0]             rdata;

    assign bytes_h  = lmem[lrd[LAW-1:0]];
    assign alen     = (CW'(bytes_h) + CW'(3)) & ~CW'(3);
    assign no_wrap  = (CW'(wr) + alen) <= CW'(RING_BYTES);
    assign start_c  = no_wrap ? wr : '0;
    // A packet that would straddle the end skips the tail and starts at 0.
    assign need     = no_wrap ? alen : CW'(RING_BYTES) - CW'(wr) + alen;
    assign free     = (CW'(bus.rd_ptr) - CW'(wr) - CW'(4)) & CW'(RING_BYTES - 1);
    assign space_ok = need <= free;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= S_IDLE;
            wr          <= '0;
            next_wr_r   <= '0;
            words_left  <= '0;
            drd         <= '0;
            lrd         <= '0;
            cmd_valid_r <= 1'b0;
            cmd_addr_r  <= ADDRESS_BITS'(RING_BASE);
            cmd_bytes_r <= '0;
            pkt_done_r  <= 1'b0;
        end else begin
            pkt_done_r <= 1'b0;
            case (state)
                S_IDLE: if (!len_empty) state <= S_CHECK;
                S_CHECK: if (space_ok) begin
                    cmd_valid_r <= 1'b1;
                    cmd_addr_r  <= ADDRESS_BITS'(RING_BASE) + ADDRESS_BITS'(start_c);
                    cmd_bytes_r <= LENGTH_BITS'(bytes_h);
                    words_left  <= (DAW+1)'(alen >> 2);
                    next_wr_r   <= RBW'(CW'(start_c) + alen);
                    state       <= S_CMD;
                end
                S_CMD: if (bus.cmd_ready) begin
                    cmd_valid_r <= 1'b0;
                    state       <= S_DATA;
                end
                S_DATA: if (bus.dout_tready) begin
                    drd        <= drd + 1'b1;
                    words_left <= words_left - 1'b1;
                    if (words_left == (DAW+1)'(1)) begin
                        lrd   <= lrd + 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: if (bus.cmd_ready) begin
                    wr         <= next_wr_r;
                    pkt_done_r <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rdata           = dmem[drd[DAW-1:0]];
    assign bus.dout_tvalid = (state == S_DATA);
    assign bus.dout_tdata  = rdata[31:0];
    assign bus.dout_tkeep  = (state == S_DATA) ? rdata[35:32] : 4'b0000;
    assign bus.dout_tlast  = (state == S_DATA) && (words_left == (DAW+1)'(1));
    assign bus.cmd_valid   = cmd_valid_r;
    assign bus.cmd_address = cmd_addr_r;
    assign bus.cmd_bytes   = cmd_bytes_r;
    assign bus.wr_ptr      = LENGTH_BITS'(wr);
    assign bus.pkt_done    = pkt_done_r;
    assign bus.drop_count  = drops;
endmodule

// File: tb/tb_pkt_ring_writer.sv
// Randomized scoreboard bench for pkt_ring_writer: a packet-level ring model
// predicts commands, data beats and write pointers; a monitor checks them.
module tb_pkt_ring_writer;
    localparam int          RB   = 256;
    localparam int          DD   = 16;
    localparam int          LD   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct { logic [31:0] addr; logic [31:0] bytes; } cmd_t;
    typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    pkt_ring_writer_if #(.ADDRESS_BITS(32), .LENGTH_BITS(32)) bus ();

    pkt_ring_writer #(
        .RING_BASE(BASE), .RING_BYTES(RB), .DATA_DEPTH(DD), .LEN_DEPTH(LD),
        .ADDRESS_BITS(32), .LENGTH_BITS(32)
    ) dut (
        .aclk(aclk), .areset(areset), .bus(bus)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_done   = 0;
    int    mwr      = 0;
    int    mdrops   = 0;
    int    dmode    = 3;
    bit    auto_rd  = 1'b1;
    cmd_t  exp_cmd[$];
    beat_t exp_beat[$];
    int    exp_wr[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Packet-level model: the ring is kept empty by the consumer, so each
    // legal packet lands at wr_ptr unless it would cross the end of the ring.
    task automatic send_pkt(input int nbytes, input bit oversize);
        beat_t beats[$];
        beat_t b;
        int nwords, nb, alen, start, rem, cnt;
        bit rdy;
        nwords = oversize ? DD + 1 : (nbytes == 0 ? 1 : (nbytes + 3) / 4);
        nb = oversize ? nwords * 4 : nbytes;
        for (int i = 0; i < nwords; i++) begin
            rem = nb - 4 * i;
            b.d = $urandom;
            b.k = (rem >= 4) ? 4'hF : (rem == 3) ? 4'h7 : (rem == 2) ? 4'h3 : (rem == 1) ? 4'h1 : 4'h0;
            b.l = (i == nwords - 1);
            beats.push_back(b);
        end
        if (nb == 0 || nwords > DD) begin
            mdrops++;
        end else begin
            cmd_t c;
            alen  = ((nb + 3) / 4) * 4;
            start = (mwr + alen > RB) ? 0 : mwr;
            c.addr  = BASE + 32'(start);
            c.bytes = 32'(nb);
            exp_cmd.push_back(c);
            foreach (beats[i]) exp_beat.push_back(beats[i]);
            mwr = (start + alen) % RB;
            exp_wr.push_back(mwr);
        end
        foreach (beats[i]) begin
            bus.s_tdata  = beats[i].d;
            bus.s_tkeep  = beats[i].k;
            bus.s_tlast  = beats[i].l;
            bus.s_tvalid = 1'b1;
            cnt = 0;
            do begin
                @(negedge aclk);
                rdy = bus.s_tready;
                @(posedge aclk);
                #1;
                cnt++;
            end while (!rdy && cnt < 2000);
            if (!rdy) check("s_tready_timeout", 0, 1);
            bus.s_tvalid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while ((exp_cmd.size() + exp_beat.size() + exp_wr.size()) != 0 && cnt < 5000) begin
            @(posedge aclk);
            cnt++;
        end
        check("drain_outstanding", exp_cmd.size() + exp_beat.size() + exp_wr.size(), 0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"},    bus.s_tready, 0);
        check({tag, "_cmd_valid"},   bus.cmd_valid, 0);
        check({tag, "_cmd_address"}, bus.cmd_address, BASE);
        check({tag, "_cmd_bytes"},   bus.cmd_bytes, 0);
        check({tag, "_dout_tvalid"}, bus.dout_tvalid, 0);
        check({tag, "_dout_tlast"},  bus.dout_tlast, 0);
        check({tag, "_dout_tkeep"},  bus.dout_tkeep, 0);
        check({tag, "_wr_ptr"},      bus.wr_ptr, 0);
        check({tag, "_pkt_done"},    bus.pkt_done, 0);
        check({tag, "_drop_count"},  bus.drop_count, 0);
    endtask

    // Monitor: pops and compares whenever the DUT presents an output.
    initial begin
        cmd_t  c;
        beat_t b;
        int    e;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    if (exp_cmd.size() == 0) check("cmd_unexpected", 1, 0);
                    else begin
                        c = exp_cmd.pop_front();
                        check("cmd_address", bus.cmd_address, c.addr);
                        check("cmd_bytes", bus.cmd_bytes, c.bytes);
                    end
                end
                if (bus.dout_tvalid && bus.dout_tready) begin
                    if (exp_beat.size() == 0) check("dout_unexpected", 1, 0);
                    else begin
                        b = exp_beat.pop_front();
                        check("dout_beat", {bus.dout_tdata, bus.dout_tkeep, bus.dout_tlast}, {b.d, b.k, b.l});
                    end
                end
                if (bus.pkt_done) begin
                    n_done++;
                    if (exp_wr.size() == 0) check("pkt_done_unexpected", 1, 0);
                    else begin
                        e = exp_wr.pop_front();
                        check("wr_ptr", bus.wr_ptr, e);
                        if (auto_rd) bus.rd_ptr = 32'(e);
                    end
                end
            end
        end
    end

    // DMA command side: busy from the cycle after handshake until the last beat.
    initial begin
        int cnt;
        bit done;
        bus.cmd_ready = 1'b1;
        forever begin
            @(negedge aclk);
            if (!areset && bus.cmd_valid && bus.cmd_ready) begin
                @(posedge aclk);
                #1;
                bus.cmd_ready = 1'b0;
                cnt  = 0;
                done = 1'b0;
                while (!done && cnt < 5000) begin
                    @(negedge aclk);
                    cnt++;
                    if (areset || (bus.dout_tvalid && bus.dout_tready && bus.dout_tlast)) done = 1'b1;
                end
                if (!done) check("dma_wait_last", 0, 1);
                @(posedge aclk);
                repeat ($urandom_range(0, 3)) @(posedge aclk);
                #1;
                bus.cmd_ready = 1'b1;
            end
        end
    end

    initial begin
        bus.dout_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (dmode)
                0:       bus.dout_tready = 1'($urandom_range(0, 1));
                1:       bus.dout_tready = !bus.dout_tready;
                2:       bus.dout_tready = 1'b0;
                default: bus.dout_tready = 1'b1;
            endcase
        end
    end

    initial begin
        int  d, cnt, r0;
        bit  seen;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tlast  = 1'b0;
        bus.rd_ptr   = '0;

        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        areset = 1'b0;
        @(negedge aclk);
        check("s_tready_after_release", bus.s_tready, 1);

        // single 10-byte packet
        @(posedge aclk);
        #1;
        n_done = 0;
        send_pkt(10, 1'b0);
        wait_idle();
        check("single_wr_ptr", bus.wr_ptr, 12);
        check("single_pkt_done_count", n_done, 1);

        // random packets, including empty ones, under random backpressure
        dmode = 0;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) == 0) send_pkt(0, 1'b0);
            else send_pkt($urandom_range(1, DD * 4), 1'b0);
        end
        wait_idle();
        check("random_drop_count", bus.drop_count, mdrops);

        // walk wr_ptr to RING_BYTES-8, then a 16-byte packet must wrap to 0
        dmode = 3;
        while (mwr != RB - 8) begin
            d = (RB - 8 - mwr + RB) % RB;
            send_pkt(d > DD * 4 ? DD * 4 : d, 1'b0);
            wait_idle();
        end
        check("wrap_setup_rd_ptr", bus.rd_ptr, RB - 8);
        send_pkt(16, 1'b0);
        wait_idle();
        check("wrap_wr_ptr", bus.wr_ptr, 16);

        // full ring: stall until the consumer frees 16 more bytes
        auto_rd = 1'b0;
        r0 = (mwr + 8) % RB;
        bus.rd_ptr = 32'(r0);
        send_pkt(16, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge aclk);
            if (bus.cmd_valid) seen = 1'b1;
        end
        check("full_ring_stall", seen, 0);
        @(posedge aclk);
        #1;
        bus.rd_ptr = 32'((r0 + 16) % RB);
        seen = 1'b0;
        repeat (2) begin
            @(negedge aclk);
            if (bus.cmd_valid) seen = 1'b1;
        end
        check("full_ring_release", seen, 1);
        wait_idle();
        bus.rd_ptr = 32'(mwr);
        auto_rd = 1'b1;

        // oversize packet then a 4-byte packet
        d = mdrops;
        send_pkt(0, 1'b1);
        send_pkt(4, 1'b0);
        wait_idle();
        check("oversize_drop_count", bus.drop_count, d + 1);

        // alternating backpressure
        dmode = 1;
        send_pkt(32, 1'b0);
        wait_idle();

        // reset while data is pending to the DMA
        dmode = 2;
        send_pkt(32, 1'b0);
        cnt = 0;
        while (!bus.dout_tvalid && cnt < 500) begin
            @(negedge aclk);
            cnt++;
        end
        check("reach_s_data", bus.dout_tvalid, 1);
        @(posedge aclk);
        #1;
        areset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_cmd.delete();
        exp_beat.delete();
        exp_wr.delete();
        mwr    = 0;
        mdrops = 0;
        bus.rd_ptr = '0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        dmode  = 0;
        send_pkt(4, 1'b0);
        wait_idle();
        check("post_reset_wr_ptr", bus.wr_ptr, 4);
        check("final_drop_count", bus.drop_count, mdrops);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
